// File: rtl/embedded_soc_gpio_pkg.sv
// embedded_soc_gpio_pkg: shared register map, edge-mode encoding and bus width
// for the GPIO controller and its synchronizer/edge-detect slice.
package embedded_soc_gpio_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {
      RISING  = 2'd0,
      FALLING = 2'd1,
      ANY     = 2'd2
   } edge_mode_e;
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
endpackage

// File: rtl/embedded_soc_gpio_sync_edge.sv
// embedded_soc_gpio_sync_edge: 2-flop pin synchronizer plus a delay stage used
// to detect per-bit edges in the selected mode.
module embedded_soc_gpio_sync_edge
   import embedded_soc_gpio_pkg::*;
#(
   parameter int         WIDTH     = 32,
   parameter edge_mode_e EDGE_MODE = RISING
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_pins,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_edge
);
   logic [WIDTH-1:0] r_s1, r_s2, r_s3;
   logic [2:0]       r_fill;
   logic [WIDTH-1:0] w_rise, w_fall;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
         r_fill <= '0;
      end else begin
         r_s1   <= i_pins;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_fill <= {r_fill[1:0], 1'b1};
      end
   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;
   // Edges are ignored until all three stages hold real pin samples after reset.
   assign o_edge = !r_fill[2] ? '0 :
                   EDGE_MODE == RISING  ? w_rise :
                   EDGE_MODE == FALLING ? w_fall : (w_rise | w_fall);
   assign o_sync = r_s2;
endmodule

// File: rtl/embedded_soc_gpio_ctrl.sv
// embedded_soc_gpio_ctrl: memory-mapped GPIO block with output data, direction,
// interrupt mask and sticky edge-capture registers.
module embedded_soc_gpio_ctrl
   import embedded_soc_gpio_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter edge_mode_e       EDGE_MODE   = RISING
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [WIDTH-1:0]  out_port,
   output logic [WIDTH-1:0]  oe_port,
   output logic              irq
);
   logic [WIDTH-1:0]  r_out, r_dir, r_mask, r_cap;
   logic [DATA_W-1:0] r_readdata, w_rdmux;
   logic              r_irq;
   logic [WIDTH-1:0]  w_sync, w_edge, w_wd, w_clr;
   logic              w_wr, w_rd, w_unused;
   embedded_soc_gpio_sync_edge #(.WIDTH(WIDTH), .EDGE_MODE(EDGE_MODE)) u_sync_edge (
      .clk    (clk),
      .rst    (reset),
      .i_pins (in_port),
      .o_sync (w_sync),
      .o_edge (w_edge)
   );
   assign w_wr     = chipselect & ~write_n;
   assign w_rd     = chipselect & write_n;
   assign w_wd     = writedata[WIDTH-1:0];
   assign w_unused = ^writedata;
   assign w_clr    = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;
   assign w_rdmux  = address == ADDR_DATA    ? DATA_W'(w_sync) :
                     address == ADDR_DIR     ? DATA_W'(r_dir)  :
                     address == ADDR_IRQMASK ? DATA_W'(r_mask) :
                     address == ADDR_EDGECAP ? DATA_W'(r_cap)  : '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_out      <= RESET_VALUE;
         r_dir      <= '0;
         r_mask     <= '0;
         r_cap      <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_out      <= !w_wr                   ? r_out          :
                       address == ADDR_DATA   ? w_wd           :
                       address == ADDR_OUTSET ? (r_out | w_wd)  :
                       address == ADDR_OUTCLR ? (r_out & ~w_wd) : r_out;
         r_dir      <= (w_wr && address == ADDR_DIR)     ? w_wd : r_dir;
         r_mask     <= (w_wr && address == ADDR_IRQMASK) ? w_wd : r_mask;
         // A fresh edge wins over a same-cycle W1C of that bit.
         r_cap      <= (r_cap & ~w_clr) | w_edge;
         r_irq      <= |(r_cap & r_mask);
         r_readdata <= w_rd ? w_rdmux : r_readdata;
      end
   assign readdata = r_readdata;
   assign out_port = r_out;
   assign oe_port  = r_dir;
   assign irq      = r_irq;
endmodule

// File: tb/tb_embedded_soc_gpio_ctrl.sv
// tb_embedded_soc_gpio_ctrl: directed plus random bus/pin stimulus on a RISING and
// an ANY instance, checked against a cycle-level behavioural model.
module tb_embedded_soc_gpio_ctrl;
   import embedded_soc_gpio_pkg::*;
   localparam int W = 8;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0, write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   rd_r, rd_a;
   logic [W-1:0]  out_r, out_a, oe_r, oe_a;
   logic          irq_r, irq_a;
   int            n_tests = 0, n_fail = 0;
   logic [W-1:0]  m_out, m_dir, m_mask;
   logic [W-1:0]  m_cap [2];
   logic          m_irq [2];
   logic [31:0]   m_rd  [2];
   logic [W-1:0]  ph [$];
   int            m_age;

   always #5 clk = ~clk;

   embedded_soc_gpio_ctrl #(.WIDTH(W), .RESET_VALUE(8'hA5), .EDGE_MODE(RISING)) dut_r (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_r), .in_port(in_port), .out_port(out_r),
      .oe_port(oe_r), .irq(irq_r));
   embedded_soc_gpio_ctrl #(.WIDTH(W), .RESET_VALUE(8'hA5), .EDGE_MODE(ANY)) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_a), .in_port(in_port), .out_port(out_a),
      .oe_port(oe_a), .irq(irq_a));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 8'hA5; m_dir = '0; m_mask = '0; m_age = 0;
      for (int m = 0; m < 2; m++) begin m_cap[m] = '0; m_irq[m] = 1'b0; m_rd[m] = '0; end
      ph = {};
      repeat (3) ph.push_back('0);
   endtask

   // Pins seen by DATA reads lag two samples; an edge compares that with one sample older.
   task automatic step();
      logic [W-1:0] s, o, wd, det;
      m_age++;
      ph.push_back(in_port);
      if (ph.size() > 8) void'(ph.pop_front());
      s  = ph[ph.size()-3];
      o  = ph[ph.size()-4];
      wd = writedata[W-1:0];
      for (int m = 0; m < 2; m++) begin
         m_irq[m] = (m_cap[m] & m_mask) != '0;
         if (chipselect && write_n)
            case (address)
               3'd0:    m_rd[m] = 32'(s);
               3'd1:    m_rd[m] = 32'(m_dir);
               3'd2:    m_rd[m] = 32'(m_mask);
               3'd3:    m_rd[m] = 32'(m_cap[m]);
               default: m_rd[m] = '0;
            endcase
         det = '0;
         for (int b = 0; b < W; b++)
            if (m_age >= 4 && s[b] != o[b] && (m == 1 || s[b])) det[b] = 1'b1;
         if (chipselect && !write_n && address == 3'd3) m_cap[m] = m_cap[m] & ~wd;
         m_cap[m] = m_cap[m] | det;
      end
      if (chipselect && !write_n)
         case (address)
            3'd0:    m_out = wd;
            3'd1:    m_dir = wd;
            3'd2:    m_mask = wd;
            3'd4:    m_out = m_out | wd;
            3'd5:    m_out = m_out & ~wd;
            default: ;
         endcase
   endtask

   task automatic cmp_all();
      chk("out_r", 32'(out_r), 32'(m_out));
      chk("out_a", 32'(out_a), 32'(m_out));
      chk("oe_r", 32'(oe_r), 32'(m_dir));
      chk("oe_a", 32'(oe_a), 32'(m_dir));
      chk("irq_r", 32'(irq_r), 32'(m_irq[0]));
      chk("irq_a", 32'(irq_a), 32'(m_irq[1]));
      chk("rd_r", rd_r, m_rd[0]);
      chk("rd_a", rd_a, m_rd[1]);
   endtask

   task automatic cyc();
      @(posedge clk);
      step();
      #1;
      cmp_all();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      cyc();
   endtask

   task automatic rd(input logic [2:0] a);
      chipselect = 1'b1; write_n = 1'b1; address = a; writedata = $urandom;
      cyc();
   endtask

   task automatic idle(input int n);
      chipselect = 1'b0; write_n = 1'b1;
      repeat (n) cyc();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(out_r), 32'hA5);
      chk("rst_oe", 32'(oe_r), 32'h0);
      chk("rst_irq", 32'(irq_r), 32'h0);
      chk("rst_rd", rd_r, 32'h0);
      reset = 1'b0;
      idle(2);
      wr(3'd0, 32'hFFFF_FF0F);
      chk("data_wr", 32'(out_r), 32'h0F);
      wr(3'd4, 32'h0000_0030);
      chk("outset", 32'(out_r), 32'h3F);
      wr(3'd5, 32'h0000_0001);
      chk("outclr", 32'(out_r), 32'h3E);
      idle(1);
      wr(3'd1, 32'h0000_005A);
      rd(3'd1);
      chk("dir_rd", rd_r, 32'h5A);
      chk("oe_dir", 32'(oe_r), 32'h5A);
      idle(1);
      chk("rd_hold", rd_r, 32'h5A);
      rd(3'd6);
      chk("rsv6", rd_r, 32'h0);
      rd(3'd4);
      chk("outset_rd", rd_r, 32'h0);
      wr(3'd2, 32'hFFFF_FF04);
      rd(3'd2);
      chk("mask_hi0", rd_r, 32'h04);
      idle(1);
      in_port = 8'h04;
      idle(4);
      rd(3'd3);
      chk("cap_r", rd_r, 32'h04);
      chk("cap_a", rd_a, 32'h04);
      chk("irq_set", 32'(irq_r), 32'h1);
      wr(3'd3, 32'h0000_0004);
      idle(1);
      chk("irq_clr", 32'(irq_r), 32'h0);
      chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h0;
      cyc();
      chk("cs0_nowr", 32'(out_r), 32'h3E);
      in_port = 8'h05;
      idle(2);
      wr(3'd3, 32'h0000_0001);
      rd(3'd3);
      chk("edge_prio_r", rd_r, 32'h01);
      chk("edge_prio_a", rd_a, 32'h01);
      wr(3'd3, 32'h0000_00FF);
      idle(1);
      in_port = 8'h01;
      idle(4);
      rd(3'd3);
      chk("fall_r", rd_r, 32'h0);
      chk("fall_a", rd_a, 32'h04);
      idle(1);
      for (int i = 0; i < 300; i++) begin
         chipselect = 1'($urandom_range(0, 1));
         write_n = 1'($urandom_range(0, 1));
         address = 3'($urandom_range(0, 7));
         writedata = $urandom;
         if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
         cyc();
      end
      idle(1);
      in_port = 8'hFF;
      wr(3'd1, 32'h0000_005A);
      rd(3'd1);
      chk("pre_rst_rd", rd_r, 32'h5A);
      #2 reset = 1'b1;
      #1;
      chk("arst_rd_r", rd_r, 32'h0);
      chk("arst_rd_a", rd_a, 32'h0);
      chk("arst_out", 32'(out_r), 32'hA5);
      chk("arst_oe", 32'(oe_r), 32'h0);
      chk("arst_irq", 32'(irq_a), 32'h0);
      model_reset();
      chipselect = 1'b0; write_n = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(6);
      rd(3'd3);
      chk("no_cap_post_rst_r", rd_r, 32'h0);
      chk("no_cap_post_rst_a", rd_a, 32'h0);
      rd(3'd0);
      chk("sync_ff", rd_r, 32'hFF);
      idle(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/embedded_soc_gpio_ctrl.md
EMBEDDED_SOC_GPIO_CTRL -- requirements
Module: embedded_soc_gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of GPIO bits (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, reset value of the output data register (WIDTH bits).
REQ-003 SHALL have parameter EDGE_MODE, default RISING, edge-capture mode: RISING, FALLING or ANY.
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port address  input  3  register word offset.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous pin inputs.
REQ-012 SHALL have port out_port  output  WIDTH  output data register.
REQ-013 SHALL have port oe_port  output  WIDTH  per-bit output enable (the direction register).
REQ-014 SHALL have port irq  output  1  level interrupt.

Function
REQ-015 SHALL use this register map: 0 DATA (R: synced pins, W: out data), 1 DIRECTION (RW, 1 = output), 2 IRQMASK (RW), 3 EDGECAP (R; W1C), 4 OUTSET (WO, W1S on out data), 5 OUTCLEAR (WO, W1C on out data), 6-7 reserved.
REQ-016 SHALL accept a write only when chipselect=1 and write_n=0; otherwise no state changes from the bus.
REQ-017 SHALL return read data one cycle after chipselect=1 with write_n=1 (read latency 1); readdata holds its value otherwise.
REQ-018 SHALL read 0 from OUTSET, OUTCLEAR, reserved offsets and from bits [31:WIDTH].
REQ-019 SHALL ignore writedata bits [31:WIDTH].
REQ-020 SHALL pass in_port through a 2-flop synchronizer; DATA reads return the second stage, 2-3 cycles after a pin change.
REQ-021 SHALL detect edges by comparing the second synchronizer stage with a third delay stage, per EDGE_MODE.
REQ-022 SHALL set EDGECAP bit n on a detected edge of bit n; the bit is sticky until cleared by writing 1 to it.
REQ-023 SHALL give a detected edge priority over a simultaneous W1C of the same bit: the bit stays 1.
REQ-024 SHALL drive irq = OR over (EDGECAP & IRQMASK), registered, asserting one cycle after the qualifying bit is set.
REQ-025 SHALL make a DATA write, OUTSET or OUTCLEAR take effect on out_port the cycle after the write.
REQ-026 SHALL not gate out_port with DIRECTION; oe_port = DIRECTION.

Reset
REQ-027 SHALL on reset set out data = RESET_VALUE and set DIRECTION, IRQMASK, EDGECAP, readdata, irq and all synchronizer and delay stages to 0.
REQ-028 SHALL apply reset immediately and asynchronously; a mid-transfer read returns 0; no edge is captured on the first cycles after release, because the stages start at 0 and the synchronizer fills before comparison.

Structure
REQ-029 SHALL take register offsets, the EDGE_MODE encoding and data width 32 from a shared package embedded_soc_gpio_pkg.
REQ-030 SHALL instantiate one sub-module, embedded_soc_gpio_sync_edge (per-bit synchronizer and edge detector, WIDTH and EDGE_MODE parametrised).

Verification
REQ-031 SHALL cover: reset with RESET_VALUE=0xA5, WIDTH=8 -> out_port=0xA5, oe_port=0, irq=0, readdata=0.
REQ-032 SHALL cover: write DATA=0x0F, then OUTSET=0x30, then OUTCLEAR=0x01 -> out_port 0x0F, 0x3F, 0x3E on successive cycles.
REQ-033 SHALL cover: in_port bit2 0->1 (RISING), IRQMASK=0x04 -> EDGECAP reads 0x04; irq=1; write EDGECAP=0x04 -> irq=0 next cycle.
REQ-034 SHALL cover: edge on bit0 in the same cycle as a W1C of bit0 -> EDGECAP bit0 remains 1.
REQ-035 SHALL cover: read address 6 and bits above WIDTH=8 -> 0; a write with chipselect=0 -> no change.
REQ-036 SHALL cover: EDGE_MODE=ANY, pin toggles 1->0 -> capture; reset asserted mid-read -> readdata=0 asynchronously.
